// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file.
package rf_pkg;

    // Sweep/run state of the clear sequencer.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then
// raises ready. Holding the sweep here lets the storage array stay reset-free.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_t         state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [ADDR_W-1:0] clr_idx_d;
    logic              ready_q;

    assign clr_idx_d = clr_idx_q + ADDR_W'(1);

    // Sweep FSM: one entry per edge, wraps to 0 and enters RUN after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    clr_idx_q <= clr_idx_d;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end
                end
                RF_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= RF_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = clr_idx_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_READ combinational read ports, one
// synchronous write port, entry 0 hard-wired to zero, post-reset clear sweep.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reg_write,
    input  logic [ADDR_W-1:0]            write_reg,
    input  logic [DATA_W-1:0]            write_data,
    input  logic [NUM_READ*ADDR_W-1:0]   read_reg,
    output logic [NUM_READ*DATA_W-1:0]   read_data,
    output logic                         ready,
    output logic                         wr_dropped
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_nonzero;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_dropped_q;
    logic              wr_dropped_d;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .ready_o   (ready),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign wr_nonzero = reg_write && (write_reg != ZERO_ADDR);
    assign user_we    = ready && wr_nonzero;

    // Sweep owns the write port until ready; user writes are only taken in RUN.
    always_comb begin
        wr_en   = user_we;
        wr_addr = write_reg;
        wr_data = write_data;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign wr_dropped_d = wr_dropped_q || (!ready && wr_nonzero);

    // Sticky flag for non-zero-address writes arriving before ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= wr_dropped_d;
        end
    end

    assign wr_dropped = wr_dropped_q;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;

        assign rd_addr = read_reg[i*ADDR_W +: ADDR_W];

        // Read port: zero during the sweep and for entry 0, else array (or bypass).
        always_comb begin
            rd_data = '0;
            if (ready && (rd_addr != ZERO_ADDR)) begin
`ifdef RF_BYPASS_EN
                if (user_we && (rd_addr == write_reg)) begin
                    rd_data = write_data;
                end else begin
                    rd_data = mem_q[rd_addr];
                end
`else
                rd_data = mem_q[rd_addr];
`endif
            end
        end

        assign read_data[i*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default instance (32b, 5b addr,
// 2 read ports) and a small instance (16b, 3b addr, 4 read ports).
module tb_param_register_file;

    logic        clk;
    int          n_cmp;
    int          n_err;

    // default-parameter instance
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [9:0]  read_reg;
    logic [63:0] read_data;
    logic        ready;
    logic        wr_dropped;

    // small instance
    logic        rst2;
    logic        we2;
    logic [2:0]  wreg2;
    logic [15:0] wdata2;
    logic [11:0] rreg2;
    logic [63:0] rdata2;
    logic        ready2;
    logic        drop2;

    param_register_file #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg  (read_reg),
        .read_data (read_data),
        .ready     (ready),
        .wr_dropped(wr_dropped)
    );

    param_register_file #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4)) dut2 (
        .clk       (clk),
        .rst       (rst2),
        .reg_write (we2),
        .write_reg (wreg2),
        .write_data(wdata2),
        .read_reg  (rreg2),
        .read_data (rdata2),
        .ready     (ready2),
        .wr_dropped(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        read_reg = {a1, a0};
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        edge1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        edge1();
        set_rd(5'd7, 5'd31);
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
        n_cmp++; if (wr_dropped !== 1'b0) begin n_err++; $display("FAIL rst_dropped got %b want 0", wr_dropped); end
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", read_data); end
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            if (e == 32) begin
                // write in the final sweep cycle must be dropped
                reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h0000CAFE;
            end
            edge1();
            reg_write = 1'b0;
            if (e < 32) begin
                n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL sweep_ready e=%0d got %b want 0", e, ready); end
                set_rd(5'(e), 5'(31 - e));
                n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL sweep_rdata e=%0d got %h want 0", e, read_data); end
            end
        end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL sweep_done_ready got %b want 1", ready); end
        n_cmp++; if (wr_dropped !== 1'b1) begin n_err++; $display("FAIL last_edge_drop got %b want 1", wr_dropped); end
        set_rd(5'd5, 5'd0);
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL last_edge_r5 got %h want 0", read_data); end
    endtask

    task automatic test_write();
        set_rd(5'd7, 5'd7);
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hDEADBEEF;
        edge1();
        reg_write = 1'b0;
        n_cmp++; if (read_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin n_err++; $display("FAIL wr_r7 got %h want deadbeefdeadbeef", read_data); end
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h00001234;
        edge1();
        reg_write = 1'b0;
        set_rd(5'd0, 5'd7);
        n_cmp++; if (read_data !== {32'hDEADBEEF, 32'h0}) begin n_err++; $display("FAIL wr_r0 got %h want deadbeef00000000", read_data); end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h11111111;
        edge1();
        set_rd(5'd7, 5'd9);
        write_data = 32'hA5A5A5A5;
        #1;
`ifdef RF_BYPASS_EN
        n_cmp++; if (read_data[63:32] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_same got %h want a5a5a5a5", read_data[63:32]); end
`else
        n_cmp++; if (read_data[63:32] !== 32'h11111111) begin n_err++; $display("FAIL nobypass_same got %h want 11111111", read_data[63:32]); end
`endif
        n_cmp++; if (read_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_other got %h want deadbeef", read_data[31:0]); end
        edge1();
        reg_write = 1'b0;
        n_cmp++; if (read_data[63:32] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_after got %h want a5a5a5a5", read_data[63:32]); end
        // address 0 never forwards
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h55555555;
        set_rd(5'd0, 5'd0);
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL bypass_r0 got %h want 0", read_data); end
        edge1();
        reg_write = 1'b0;
    endtask

    task automatic test_dropped();
        // give r3 a value first so a leaked write or a missed clear would show
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h0BADF00D;
        edge1();
        reg_write = 1'b0;
        pulse_reset();
        n_cmp++; if (wr_dropped !== 1'b0) begin n_err++; $display("FAIL drop_rst got %b want 0", wr_dropped); end
        for (int e = 1; e <= 32; e++) begin
            if (e == 5)  begin reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h77; end
            if (e == 10) begin reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h33; end
            edge1();
            reg_write = 1'b0;
            if (e == 5 || e == 9) begin
                n_cmp++; if (wr_dropped !== 1'b0) begin n_err++; $display("FAIL drop_early e=%0d got %b want 0", e, wr_dropped); end
            end
            if (e == 10 || e == 20) begin
                n_cmp++; if (wr_dropped !== 1'b1) begin n_err++; $display("FAIL drop_set e=%0d got %b want 1", e, wr_dropped); end
            end
        end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL drop_ready got %b want 1", ready); end
        n_cmp++; if (wr_dropped !== 1'b1) begin n_err++; $display("FAIL drop_sticky got %b want 1", wr_dropped); end
        set_rd(5'd3, 5'd3);
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL drop_r3 got %h want 0", read_data); end
    endtask

    task automatic test_rst_mid_run();
        for (int i = 1; i < 32; i++) begin
            reg_write = 1'b1; write_reg = 5'(i); write_data = 32'(i);
            edge1();
        end
        reg_write = 1'b0;
        set_rd(5'd1, 5'd31);
        n_cmp++; if (read_data !== {32'd31, 32'd1}) begin n_err++; $display("FAIL fill_r1_r31 got %h want 0000001f00000001", read_data); end
        set_rd(5'd17, 5'd30);
        n_cmp++; if (read_data !== {32'd30, 32'd17}) begin n_err++; $display("FAIL fill_r17_r30 got %h want 0000001e00000011", read_data); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL midrun_ready got %b want 0", ready); end
        n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL midrun_rdata got %h want 0", read_data); end
        edge1();
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            edge1();
            if (e == 31) begin
                n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL resweep_e31 got %b want 0", ready); end
            end
        end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL resweep_e32 got %b want 1", ready); end
        for (int i = 0; i < 16; i++) begin
            set_rd(5'(i), 5'(i + 16));
            n_cmp++; if (read_data !== 64'h0) begin n_err++; $display("FAIL cleared r%0d/r%0d got %h want 0", i, i + 16, read_data); end
        end
    endtask

    task automatic test_param4();
        rst2 = 1'b1;
        edge1();
        rst2 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            edge1();
            if (e == 7) begin
                n_cmp++; if (ready2 !== 1'b0) begin n_err++; $display("FAIL p4_e7_ready got %b want 0", ready2); end
            end
        end
        n_cmp++; if (ready2 !== 1'b1) begin n_err++; $display("FAIL p4_e8_ready got %b want 1", ready2); end
        for (int i = 1; i < 8; i++) begin
            we2 = 1'b1; wreg2 = 3'(i); wdata2 = 16'h1000 | 16'(i * 16'h0111);
            edge1();
        end
        we2 = 1'b0;
        rreg2 = {3'd0, 3'd5, 3'd2, 3'd7};
        #1;
        n_cmp++; if (rdata2 !== {16'h0000, 16'h1555, 16'h1222, 16'h1777}) begin n_err++; $display("FAIL p4_rd_a got %h want 0000155512221777", rdata2); end
        rreg2 = {3'd6, 3'd4, 3'd3, 3'd1};
        #1;
        n_cmp++; if (rdata2 !== {16'h1666, 16'h1444, 16'h1333, 16'h1111}) begin n_err++; $display("FAIL p4_rd_b got %h want 1666144413331111", rdata2); end
        n_cmp++; if (drop2 !== 1'b0) begin n_err++; $display("FAIL p4_dropped got %b want 0", drop2); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0; read_reg = '0;
        rst2 = 1'b1; we2 = 1'b0; wreg2 = '0; wdata2 = '0; rreg2 = '0;
        test_reset();
        test_write();
        test_bypass();
        test_dropped();
        test_rst_mid_run();
        test_param4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
